// File: rtl/ps2_keyboard_receiver_if.sv
// Key-event port between the PS/2 receiver and the SoC keyboard logic.
interface ps2_keyboard_receiver_if;
  logic [7:0] keyCode;
  logic       keyExtended;
  logic       keyReleased;
  logic       keyValid;
  logic       keyAck;

  modport master (output keyCode, keyExtended, keyReleased, keyValid, input keyAck);
  modport slave  (input keyCode, keyExtended, keyReleased, keyValid, output keyAck);
endinterface

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 frame receiver with scan-code-set-2 prefix decode, modifier tracking
// and a single-entry valid/ack holding register.
module ps2_keyboard_receiver #(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2Clk,
  input  logic ps2Data,
  ps2_keyboard_receiver_if.master kbd,
  output logic overrun,
  output logic frameError,
  output logic shift,
  output logic ctrl,
  output logic alt
);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [14:0] TO_LAST = 15'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  PFX_EXT = 8'hE0;
  localparam logic [7:0]  PFX_REL = 8'hF0;

  state_t      state;
  logic [1:0]  clkSync, dataSync;
  logic        clkDly, fallEdge, bitD;
  logic [2:0]  bitCount;
  logic [7:0]  shreg;
  logic        parBit;
  logic [14:0] toCnt;
  logic        ext, rel;
  logic        lShift, rShift, lCtrl, rCtrl, lAlt, rAlt;
  logic        goodFrame, keyEvent;

  // Synchronizers idle high so reset never fakes a falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clkSync  <= 2'b11;
      dataSync <= 2'b11;
      clkDly   <= 1'b1;
      fallEdge <= 1'b0;
      bitD     <= 1'b1;
    end else begin
      clkSync  <= {clkSync[0], ps2Clk};
      dataSync <= {dataSync[0], ps2Data};
      clkDly   <= clkSync[1];
      fallEdge <= clkDly & ~clkSync[1];
      bitD     <= dataSync[1];
    end
  end

  always_comb begin
    goodFrame = fallEdge && (state == STOP) && bitD && (^{shreg, parBit});
    keyEvent  = goodFrame && (shreg != PFX_EXT) && (shreg != PFX_REL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      bitCount        <= '0;
      shreg           <= '0;
      parBit          <= 1'b0;
      toCnt           <= '0;
      ext             <= 1'b0;
      rel             <= 1'b0;
      {lShift, rShift, lCtrl, rCtrl, lAlt, rAlt} <= '0;
      kbd.keyCode     <= '0;
      kbd.keyExtended <= 1'b0;
      kbd.keyReleased <= 1'b0;
      kbd.keyValid    <= 1'b0;
      overrun         <= 1'b0;
      frameError      <= 1'b0;
    end else begin
      frameError <= 1'b0;

      // Timeout only runs mid-frame; prefix flags survive a discarded frame.
      if (state == IDLE || fallEdge) begin
        toCnt <= '0;
      end else if (toCnt == TO_LAST) begin
        toCnt      <= '0;
        state      <= IDLE;
        frameError <= 1'b1;
      end else begin
        toCnt <= toCnt + 15'd1;
      end

      if (fallEdge) begin
        case (state)
          IDLE: begin
            if (!bitD) begin
              state    <= DATA;
              bitCount <= '0;
            end else begin
              frameError <= 1'b1;
            end
          end
          DATA: begin
            shreg    <= {bitD, shreg[7:1]};
            bitCount <= bitCount + 3'd1;
            if (bitCount == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parBit <= bitD;
            state  <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!goodFrame)               frameError <= 1'b1;
            else if (shreg == PFX_EXT)    ext <= 1'b1;
            else if (shreg == PFX_REL)    rel <= 1'b1;
            else begin
              ext <= 1'b0;
              rel <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end

      if (keyEvent) begin
        case (shreg)
          8'h12: lShift <= ~rel;
          8'h59: rShift <= ~rel;
          8'h14: if (ext) rCtrl <= ~rel; else lCtrl <= ~rel;
          8'h11: if (ext) rAlt  <= ~rel; else lAlt  <= ~rel;
          default: ;
        endcase
      end

      // Same-cycle ack frees the slot for the incoming event.
      if (keyEvent) begin
        if (!kbd.keyValid || kbd.keyAck) begin
          kbd.keyCode     <= shreg;
          kbd.keyExtended <= ext;
          kbd.keyReleased <= rel;
          kbd.keyValid    <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (kbd.keyAck && kbd.keyValid) begin
        kbd.keyValid <= 1'b0;
        overrun      <= 1'b0;
      end
    end
  end

  assign shift = lShift | rShift;
  assign ctrl  = lCtrl  | rCtrl;
  assign alt   = lAlt   | rAlt;
endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Randomized scoreboard bench for ps2_keyboard_receiver.
module tb_ps2_keyboard_receiver;
  localparam int TO   = 100;
  localparam int HALF = 10;

  typedef struct {
    logic [7:0] code;
    logic ext, rel, sh, ct, al;
  } ev_t;

  logic clk = 1'b0, reset = 1'b0, ps2Clk = 1'b1, ps2Data = 1'b1;
  logic overrun, frameError, shift, ctrl, alt;
  logic monAck = 1'b0, dirAck = 1'b0, monEn = 1'b1, pushEn = 1'b1;
  int   checks = 0, errors = 0, errCnt = 0, errExp = 0;
  ev_t  q[$];

  // Reference state: prefix flags and one bit per physical modifier key.
  logic mExt = 0, mRel = 0;
  logic lsh = 0, rsh = 0, lct = 0, rct = 0, lal = 0, ral = 0;

  ps2_keyboard_receiver_if kbd();
  assign kbd.keyAck = monAck | dirAck;

  ps2_keyboard_receiver #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ps2Clk(ps2Clk), .ps2Data(ps2Data), .kbd(kbd),
    .overrun(overrun), .frameError(frameError), .shift(shift), .ctrl(ctrl), .alt(alt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model(input logic [7:0] b);
    ev_t e;
    if (b == 8'hE0) mExt = 1;
    else if (b == 8'hF0) mRel = 1;
    else begin
      if (b == 8'h12) lsh = !mRel;
      if (b == 8'h59) rsh = !mRel;
      if (b == 8'h14) begin if (mExt) rct = !mRel; else lct = !mRel; end
      if (b == 8'h11) begin if (mExt) ral = !mRel; else lal = !mRel; end
      e.code = b; e.ext = mExt; e.rel = mRel;
      e.sh = lsh | rsh; e.ct = lct | rct; e.al = lal | ral;
      if (pushEn) q.push_back(e);
      mExt = 0; mRel = 0;
    end
  endtask

  // nBits < 11 sends a truncated frame; ackOnStop raises keyAck on the event cycle.
  task automatic sendFrame(input logic [7:0] b, input bit parErr, input bit stopErr,
                           input int nBits, input bit ackOnStop);
    logic [10:0] bits;
    bits = {~stopErr, (~^b) ^ parErr, b, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      ps2Data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2Clk = 1'b0;
      if (ackOnStop && i == 10) begin
        repeat (3) @(negedge clk);
        dirAck = 1'b1;
        @(negedge clk);
        dirAck = 1'b0;
        repeat (HALF - 4) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2Clk = 1'b1;
    end
    ps2Data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic sendGood(input logic [7:0] b);
    model(b);
    sendFrame(b, 0, 0, 11, 0);
  endtask

  // Monitor: pops the expected event whenever the holding register fills, then acks.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (monEn && reset && kbd.keyValid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event: code %h with empty scoreboard", kbd.keyCode);
        end else begin
          e = q.pop_front();
          chk("event{code,ext,rel,shift,ctrl,alt}",
              32'({kbd.keyCode, kbd.keyExtended, kbd.keyReleased, shift, ctrl, alt}),
              32'({e.code, e.ext, e.rel, e.sh, e.ct, e.al}));
        end
        monAck = 1'b1;
        @(negedge clk);
        monAck = 1'b0;
      end
    end
  end

  always @(negedge clk) if (reset && frameError) errCnt++;

  initial begin
    logic [7:0] b;
    logic [7:0] mods [4];
    mods[0] = 8'h12; mods[1] = 8'h59; mods[2] = 8'h14; mods[3] = 8'h11;
    repeat (5) @(negedge clk);
    chk("reset_outputs", 32'({kbd.keyCode, kbd.keyExtended, kbd.keyReleased, kbd.keyValid,
                              overrun, frameError, shift, ctrl, alt}), 32'h0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    sendGood(8'h1C);
    chk("ack_clears_valid", 32'(kbd.keyValid), 32'h0);
    sendGood(8'hE0); sendGood(8'hF0); sendGood(8'h75); sendGood(8'h1C);
    sendGood(8'h12); sendGood(8'h59); sendGood(8'hF0); sendGood(8'h12);
    sendGood(8'hF0); sendGood(8'h59);
    chk("shift_released", 32'(shift), 32'h0);
    sendGood(8'hE0); sendGood(8'h14);
    chk("right_ctrl_held", 32'(ctrl), 32'h1);

    sendFrame(8'h1C, 1, 0, 11, 0);
    sendFrame(8'h1C, 0, 1, 11, 0);
    errExp += 2;
    chk("bad_parity_stop_errors", 32'(errCnt), 32'(errExp));
    chk("no_valid_after_errors", 32'(kbd.keyValid), 32'h0);

    sendFrame(8'h1C, 0, 0, 4, 0);
    repeat (TO + 20) @(negedge clk);
    errExp += 1;
    chk("timeout_single_error", 32'(errCnt), 32'(errExp));
    sendGood(8'h1C);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0, 1:    b = mods[$urandom_range(0, 3)];
        2:       b = 8'hE0;
        3:       b = 8'hF0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 9) == 0) begin
        errExp++;
        if ($urandom_range(0, 1) == 1) sendFrame(b, 1, 0, 11, 0);
        else                           sendFrame(b, 0, 1, 11, 0);
      end else begin
        sendGood(b);
      end
    end
    chk("random_error_count", 32'(errCnt), 32'(errExp));
    chk("scoreboard_drained", 32'(q.size()), 32'h0);

    // Overrun handling with the consumer held off.
    if (mExt || mRel) sendGood(8'h00);
    monEn = 1'b0; pushEn = 1'b0;
    sendGood(8'h1C);
    chk("hold_first", 32'({kbd.keyValid, kbd.keyCode}), 32'h11C);
    sendGood(8'h32);
    chk("overrun_keeps_code", 32'({kbd.keyValid, overrun, kbd.keyCode}), 32'h31C);
    model(8'h33);
    sendFrame(8'h33, 0, 0, 11, 1);
    chk("ack_same_cycle_load", 32'({kbd.keyValid, overrun, kbd.keyCode}), 32'h333);
    dirAck = 1'b1;
    @(negedge clk);
    dirAck = 1'b0;
    @(negedge clk);
    chk("ack_clears_overrun", 32'({kbd.keyValid, overrun}), 32'h0);
    chk("final_error_count", 32'(errCnt), 32'(errExp));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1);
  end
endmodule
